instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// instruction_fetch_unit: single-outstanding instruction fetcher with stall hold,
// deferred branch redirect and WAIT timeout/retry. Revision 1.0
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READINST,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    output logic        IF_VALID,
    output logic        FETCH_ERR
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [31:0]      pc, pc_next;
    logic [31:0]      instr_next, if_pc_next;
    logic [31:0]      pend_target, pend_target_next;
    logic             pend_valid, pend_valid_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             err_next;
    logic [31:0]      branch_aligned;
    logic             redirect;
    logic [31:0]      redirect_target;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            IF_INSTR    <= 32'd0;
            IF_PC       <= 32'd0;
            FETCH_ERR   <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            IF_INSTR    <= instr_next;
            IF_PC       <= if_pc_next;
            FETCH_ERR   <= err_next;
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;
            wait_cnt    <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = IF_INSTR;
        if_pc_next       = IF_PC;
        err_next         = 1'b0;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
        wait_cnt_next    = wait_cnt;
        IMEM_READ        = 1'b0;
        IMEM_ADDRESS     = pc;
        IF_VALID         = 1'b0;

        branch_aligned  = BRANCH_TARGET & ~32'h0000_0003;
        // A branch arriving this cycle overrides any older pending target.
        redirect        = BRANCH_TAKEN | pend_valid;
        redirect_target = BRANCH_TAKEN ? branch_aligned : pend_target;

        if (BRANCH_TAKEN) begin
            pend_valid_next  = 1'b1;
            pend_target_next = branch_aligned;
        end

        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                IMEM_READ     = 1'b1;
                wait_cnt_next = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                IMEM_READ = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    if (redirect) begin
                        // Access completes but its word is dropped in favour of the redirect.
                        pc_next         = redirect_target;
                        pend_valid_next = 1'b0;
                        state_next      = S_REQ;
                    end else begin
                        instr_next = IMEM_READINST;
                        if_pc_next = pc;
                        state_next = S_HOLD;
                    end
                end else if (wait_cnt == CNT_LAST) begin
                    err_next      = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = S_REQ;
                    if (redirect) begin
                        pc_next         = redirect_target;
                        pend_valid_next = 1'b0;
                    end
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                IF_VALID = 1'b1;
                if (!STALL) begin
                    pc_next         = redirect ? redirect_target : pc + 32'd4;
                    pend_valid_next = 1'b0;
                    state_next      = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire
